multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Sequencing front-end for the iterative radix-4 Booth multiplier and the iterative divider.
- Latches operands when a ctrl_MULT or ctrl_DIV pulse arrives, then drives each unit's operand and counter inputs while the operation runs.
- Samples the unit's result and error flag at the fixed completion count and presents them with a one-cycle ready pulse.
- Sits between the ALU/execute stage and the multiplier/divider datapaths.

Parameters:
- MULT_LAT, 17: counter value at which mult_product/mult_overflow are valid and sampled.
- DIV_LAT, 33: counter value at which div_quotient/div_exception are valid and sampled.
- CNT_W, 6: internal counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ctrl_MULT  in  1  one-cycle start pulse for multiply.
- ctrl_DIV  in  1  one-cycle start pulse for divide.
- data_operandA  in  32  multiplicand / dividend.
- data_operandB  in  32  multiplier / divisor.
- mult_multiplicand  out  32  latched A to the multiplier.
- mult_multiplier  out  32  latched B to the multiplier.
- mult_counter  out  32  multiplier iteration count, zero-extended from CNT_W.
- mult_product  in  32  multiplier result.
- mult_overflow  in  1  multiplier overflow.
- div_dividend  out  32  latched A to the divider.
- div_divisor  out  32  latched B to the divider.
- div_counter  out  32  divider iteration count, zero-extended.
- div_quotient  in  32  divider result.
- div_exception  in  1  divider error flag.
- data_result  out  32  final result; held until the next completion.
- data_exception  out  1  overflow, divide-by-zero or divider error; held with data_result.
- data_resultRDY  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async):
  - state=IDLE, counter=0, operand latches=0.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - Both counter outputs = 0.
- States are IDLE, MULT_RUN, DIV_RUN, DONE.
- Start:
  - On a clock edge with ctrl_MULT=1, latch A/B into the mult operand registers, clear the counter to 0 and enter MULT_RUN.
  - ctrl_DIV does the same for the divider and enters DIV_RUN.
  - If both are asserted, multiply wins and ctrl_DIV is ignored.
- Counter:
  - The first cycle in a RUN state presents counter=0; the unit loads its initial state on that edge.
  - The counter increments by 1 every cycle after that.
  - The inactive unit's counter output is held at 0.
- Completion:
  - In MULT_RUN with counter==MULT_LAT, register data_result=mult_product and data_exception=mult_overflow, then go to DONE.
  - DIV_RUN does the same at DIV_LAT, using div_quotient and div_exception.
- DONE: data_resultRDY=1 for exactly one cycle, then IDLE.
- Latency from the start pulse edge to data_resultRDY high is MULT_LAT+2 cycles for multiply and DIV_LAT+2 for divide.
- Divide-by-zero:
  - If the latched divisor==0, DIV_RUN goes to DONE on its first cycle.
  - data_result=0, data_exception=1, and the divider counter is not advanced.
- A new ctrl pulse in any state (including RUN) aborts the current operation and restarts with the new operands; no RDY is issued for the aborted op.
- A ctrl pulse in DONE restarts the op, and RDY still pulses that cycle for the completed op.
- Operand latches change only on a start pulse. data_result/data_exception change only on completion.

Optional Feature:
- MULTDIV_EARLY_ZERO_EN
  - Defined: in MULT_RUN at counter 0, if either latched operand==0, go directly to DONE with data_result=0 and data_exception=0 (latency 2).
  - Undefined: zero operands take the full MULT_LAT path.

Decomposition:
- Package multdiv_pkg: state enum, MULT_LAT/DIV_LAT defaults, CNT_W, the 32-bit word width constant.
- Sub-module multdiv_counter: CNT_W up-counter with synchronous clear, enable and async reset, instantiated once.

Test Plan:
- ctrl_MULT with A=7, B=6 → RDY at cycle 19 after the pulse, result=42, exception=0; mult_counter walks 0..17.
- ctrl_MULT with A=32'h7FFFFFFF, B=2 → result=32'hFFFFFFFE, exception=1.
- ctrl_DIV with A=100, B=7 → RDY at cycle 35, result=14, exception=0.
- ctrl_DIV with A=5, B=0 → RDY 2 cycles after the pulse, result=0, exception=1, div_counter stays 0.
- ctrl_MULT with A=3, B=3, then ctrl_DIV with A=9, B=3 at counter 5 → no RDY for the multiply; one RDY with result=3, DIV_LAT+2 cycles after the second pulse.
- Assert reset mid-DIV_RUN (counter=10) → all outputs 0 immediately and state IDLE; a subsequent ctrl_MULT with A=-3, B=4 → result=-12.

Source files
------------

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the multiply/divide sequencer
package multdiv_pkg;

  localparam int WORD_W       = 32;
  localparam int CNT_W        = 6;
  localparam int MULT_LAT_DEF = 17;
  localparam int DIV_LAT_DEF  = 33;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT_RUN,
    ST_DIV_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/multdiv_counter.sv
// rtl/multdiv_counter.sv - iteration up-counter with synchronous clear and enable
module multdiv_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - operand latch, iteration sequencing and result capture for mult/div units
// Optional MULTDIV_EARLY_ZERO_EN: multiply with a zero operand completes on its first run cycle.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = multdiv_pkg::CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] mult_multiplicand,
  output logic [31:0] mult_multiplier,
  output logic [31:0] mult_counter,
  input  logic [31:0] mult_product,
  input  logic        mult_overflow,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic [31:0] div_counter,
  input  logic [31:0] div_quotient,
  input  logic        div_exception,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   mcand_q, mcand_d;
  logic [WORD_W-1:0]   mplier_q, mplier_d;
  logic [WORD_W-1:0]   dvd_q, dvd_d;
  logic [WORD_W-1:0]   dvs_q, dvs_d;
  logic [WORD_W-1:0]   result_q, result_d;
  logic                exc_q, exc_d;
  logic                rdy_q, rdy_d;
  logic [CNT_W-1:0]    cnt;
  logic                cnt_clr, cnt_en;

  multdiv_counter #(.W(CNT_W)) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    exc_d    = exc_q;
    // RDY trails the DONE state by one edge so it lines up with the held result
    rdy_d    = (state_q == ST_DONE);
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    if (ctrl_MULT) begin
      state_d  = ST_MULT_RUN;
      mcand_d  = data_operandA;
      mplier_d = data_operandB;
      cnt_clr  = 1'b1;
    end else if (ctrl_DIV) begin
      state_d = ST_DIV_RUN;
      dvd_d   = data_operandA;
      dvs_d   = data_operandB;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_MULT_RUN: begin
`ifdef MULTDIV_EARLY_ZERO_EN
          if (cnt == '0 && (mcand_q == '0 || mplier_q == '0)) begin
            result_d = '0;
            exc_d    = 1'b0;
            state_d  = ST_DONE;
          end else
`endif
          if (cnt == MULT_LAT_C) begin
            result_d = mult_product;
            exc_d    = mult_overflow;
            state_d  = ST_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_DIV_RUN: begin
          // Zero divisor never reaches the divider: flag it without iterating
          if (dvs_q == '0) begin
            result_d = '0;
            exc_d    = 1'b1;
            state_d  = ST_DONE;
          end else if (cnt == DIV_LAT_C) begin
            result_d = div_quotient;
            exc_d    = div_exception;
            state_d  = ST_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign mult_multiplicand = mcand_q;
  assign mult_multiplier   = mplier_q;
  assign div_dividend      = dvd_q;
  assign div_divisor       = dvs_q;
  assign mult_counter      = (state_q == ST_MULT_RUN) ? {{(WORD_W-CNT_W){1'b0}}, cnt} : '0;
  assign div_counter       = (state_q == ST_DIV_RUN)  ? {{(WORD_W-CNT_W){1'b0}}, cnt} : '0;
  assign data_result       = result_q;
  assign data_exception    = exc_q;
  assign data_resultRDY    = rdy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - randomized self-checking bench for multdiv_ctrl
module tb_multdiv_ctrl;

  localparam int MULT_LAT = 17;
  localparam int DIV_LAT  = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] mult_multiplicand, mult_multiplier, mult_counter, mult_product;
  logic        mult_overflow;
  logic [31:0] div_dividend, div_divisor, div_counter, div_quotient;
  logic        div_exception;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev_res;
  logic        prev_exc;

  always #5 clk = ~clk;

  multdiv_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .ctrl_MULT         (ctrl_MULT),
    .ctrl_DIV          (ctrl_DIV),
    .data_operandA     (data_operandA),
    .data_operandB     (data_operandB),
    .mult_multiplicand (mult_multiplicand),
    .mult_multiplier   (mult_multiplier),
    .mult_counter      (mult_counter),
    .mult_product      (mult_product),
    .mult_overflow     (mult_overflow),
    .div_dividend      (div_dividend),
    .div_divisor       (div_divisor),
    .div_counter       (div_counter),
    .div_quotient      (div_quotient),
    .div_exception     (div_exception),
    .data_result       (data_result),
    .data_exception    (data_exception),
    .data_resultRDY    (data_resultRDY)
  );

  // Stand-in datapaths: results are only correct at the completion count, junk otherwise
  logic signed [63:0] mprod;
  assign mprod = $signed({{32{mult_multiplicand[31]}}, mult_multiplicand}) *
                 $signed({{32{mult_multiplier[31]}}, mult_multiplier});
  assign mult_product  = (mult_counter == MULT_LAT) ? mprod[31:0] : (32'hDEAD0000 ^ mult_counter);
  assign mult_overflow = (mult_counter == MULT_LAT) ? !((&mprod[63:31]) || !(|mprod[63:31])) : 1'b1;
  assign div_quotient  = (div_counter == DIV_LAT && div_divisor != 0) ?
                         32'($signed(div_dividend) / $signed(div_divisor)) : (32'hBAD00000 ^ div_counter);
  assign div_exception = (div_counter != DIV_LAT);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mult;
    ctrl_DIV      = !is_mult;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Issues one op and checks counters, RDY timing and result hold/update against the arithmetic model
  task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b, input bit rdy_first);
    int          exp_lat;
    int          exp_cnt;
    logic [31:0] exp_res;
    logic        exp_exc;
    longint      p;
    if (is_mult) begin
      p       = longint'(int'(a)) * longint'(int'(b));
      exp_res = p[31:0];
      exp_exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      exp_lat = MULT_LAT + 2;
`ifdef MULTDIV_EARLY_ZERO_EN
      if (a == 0 || b == 0) begin
        exp_res = 0;
        exp_exc = 1'b0;
        exp_lat = 2;
      end
`endif
    end else if (b == 0) begin
      exp_res = 0;
      exp_exc = 1'b1;
      exp_lat = 2;
    end else begin
      exp_res = 32'(int'(a) / int'(b));
      exp_exc = 1'b0;
      exp_lat = DIV_LAT + 2;
    end
    start(is_mult, a, b);
    check(is_mult ? "mult_opA" : "div_opA", is_mult ? mult_multiplicand : div_dividend, a);
    check(is_mult ? "mult_opB" : "div_opB", is_mult ? mult_multiplier : div_divisor, b);
    for (int k = 0; k <= exp_lat + 1; k++) begin
      if (k > 0) tick();
      exp_cnt = (k <= exp_lat - 2) ? k : 0;
      check("mult_counter", mult_counter, is_mult ? exp_cnt : 0);
      check("div_counter", div_counter, is_mult ? 0 : exp_cnt);
      check("rdy", {31'b0, data_resultRDY}, (k == exp_lat) || (k == 0 && rdy_first));
      if (k < exp_lat - 1) begin
        check("result_hold", data_result, prev_res);
        check("exc_hold", {31'b0, data_exception}, {31'b0, prev_exc});
      end else begin
        check("result", data_result, exp_res);
        check("exc", {31'b0, data_exception}, {31'b0, exp_exc});
      end
    end
    prev_res = exp_res;
    prev_exc = exp_exc;
  endtask

  initial begin
    logic [31:0] a, b;
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = 0;
    data_operandB = 0;
    prev_res = 0;
    prev_exc = 1'b0;
    repeat (2) tick();
    check("rst_result", data_result, 0);
    check("rst_exc", {31'b0, data_exception}, 0);
    check("rst_rdy", {31'b0, data_resultRDY}, 0);
    check("rst_mcnt", mult_counter, 0);
    check("rst_dcnt", div_counter, 0);
    check("rst_mcand", mult_multiplicand, 0);
    check("rst_dvs", div_divisor, 0);
    reset = 1'b0;
    tick();

    run_op(1'b1, 32'd7, 32'd6, 1'b0);
    run_op(1'b1, 32'h7FFFFFFF, 32'd2, 1'b0);
    run_op(1'b0, 32'd100, 32'd7, 1'b0);
    run_op(1'b0, 32'd5, 32'd0, 1'b0);

    // Abort a multiply at count 5 with a divide
    start(1'b1, 32'd3, 32'd3);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("abort_mcnt", mult_counter, k);
      check("abort_rdy", {31'b0, data_resultRDY}, 0);
    end
    run_op(1'b0, 32'd9, 32'd3, 1'b0);

    // Restart while in DONE: the finished op still gets its RDY pulse
    start(1'b0, 32'd5, 32'd0);
    tick();
    check("done_result", data_result, 0);
    check("done_exc", {31'b0, data_exception}, 1);
    prev_res = 0;
    prev_exc = 1'b1;
    run_op(1'b1, 32'd2, 32'd3, 1'b1);

    // Asynchronous reset in the middle of a divide
    start(1'b0, 32'd1000, 32'd7);
    repeat (10) tick();
    check("pre_rst_dcnt", div_counter, 10);
    #1 reset = 1'b1;
    #1;
    check("arst_result", data_result, 0);
    check("arst_exc", {31'b0, data_exception}, 0);
    check("arst_rdy", {31'b0, data_resultRDY}, 0);
    check("arst_dcnt", div_counter, 0);
    check("arst_mcnt", mult_counter, 0);
    check("arst_dvd", div_dividend, 0);
    check("arst_mplier", mult_multiplier, 0);
    #2 reset = 1'b0;
    prev_res = 0;
    prev_exc = 1'b0;
    tick();
    run_op(1'b1, -32'sd3, 32'd4, 1'b0);

    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 2) == 0) a = $urandom_range(0, 200) - 100;
      if ($urandom_range(0, 2) == 0) b = $urandom_range(0, 20) - 10;
      if (a == 32'h80000000) a = 32'd1;
      run_op($urandom_range(0, 1) == 1, a, b, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
